// File: rtl/e1_gen_fixed_point_if.sv
// Load port and valid/ready streaming port of the fixed-point playback generator.
// The master side preloads samples and consumes the stream; the slave side is the generator.
interface e1_gen_fixed_point_if #(
    parameter int GEN_NUM       = 100,
    parameter int N             = 64,
    parameter int GEN_NUM_WIDTH = $clog2(GEN_NUM)
);
    logic                     load_en;
    logic [GEN_NUM_WIDTH-1:0] load_index;
    logic [N-1:0]             load_data;
    logic                     module_en;
    logic                     gen_ready;
    logic                     gen_valid;
    logic [N-1:0]             gen_fixed_point;
    logic [GEN_NUM_WIDTH-1:0] gen_index;
    logic                     busy;
    logic                     module_done;

    modport master (
        output load_en, load_index, load_data, module_en, gen_ready,
        input  gen_valid, gen_fixed_point, gen_index, busy, module_done
    );

    modport slave (
        input  load_en, load_index, load_data, module_en, gen_ready,
        output gen_valid, gen_fixed_point, gen_index, busy, module_done
    );
endinterface

// File: rtl/e1_gen_fixed_point.sv
// Playback generator: GEN_NUM preloaded N-bit samples are streamed in index order
// over valid/ready, followed by a one-cycle module_done pulse. Sample bits pass
// through untouched; Q only documents the fixed-point format.
module e1_gen_fixed_point #(
    parameter int GEN_NUM       = 100,
    parameter int GEN_NUM_WIDTH = $clog2(GEN_NUM),
    parameter int N             = 64,
    parameter int Q             = 15
) (
    input  logic                clk,
    input  logic                rst,
    e1_gen_fixed_point_if.slave bus
);
    // Reject configurations the index arithmetic and data format cannot support.
    if (GEN_NUM < 2 || Q >= N) begin : g_param_check
        $error("e1_gen_fixed_point: GEN_NUM must be >= 2 and Q < N");
    end

    localparam logic [GEN_NUM_WIDTH-1:0] LAST_INDEX  = GEN_NUM_WIDTH'(GEN_NUM - 1);
    localparam logic [GEN_NUM_WIDTH:0]   GEN_NUM_EXT = (GEN_NUM_WIDTH + 1)'(GEN_NUM);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q;
    logic                     gen_valid_q;
    logic                     module_done_q;
    logic                     busy_q;
    logic [GEN_NUM_WIDTH-1:0] index_q;
    logic [N-1:0]             data_q;

    // Sample storage; never reset, survives aborted runs.
    logic [N-1:0]             buffer_mem [GEN_NUM];

    logic                     wr_en_d;
    logic                     fwd_d;
    logic [GEN_NUM_WIDTH-1:0] rd_addr_d;

    // Write decode, start-time forwarding and the single read address of the buffer.
    always_comb begin
        wr_en_d   = 1'b0;
        fwd_d     = 1'b0;
        rd_addr_d = '0;
        if (state_q == S_IDLE) begin
            // Writes only land while idle; out-of-range indices are dropped.
            wr_en_d = bus.load_en && ({1'b0, bus.load_index} < GEN_NUM_EXT);
            // A same-cycle write to index 0 must reach the output, not the stale word.
            fwd_d   = bus.load_en && (bus.load_index == '0);
        end else if (index_q != LAST_INDEX) begin
            // Prefetch the next sample; clamped at the last index to stay in range.
            rd_addr_d = index_q + GEN_NUM_WIDTH'(1);
        end else begin
            rd_addr_d = LAST_INDEX;
        end
    end

    // Buffer write port.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            buffer_mem[bus.load_index] <= bus.load_data;
        end
    end

    // Control FSM with registered outputs and the registered buffer read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            gen_valid_q   <= 1'b0;
            module_done_q <= 1'b0;
            busy_q        <= 1'b0;
            index_q       <= '0;
            data_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    module_done_q <= 1'b0;
                    if (bus.module_en) begin
                        state_q     <= S_RUN;
                        gen_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        index_q     <= '0;
                        data_q      <= fwd_d ? bus.load_data : buffer_mem[rd_addr_d];
                    end
                end
                S_RUN: begin
                    if (bus.gen_ready) begin
                        if (index_q == LAST_INDEX) begin
                            state_q       <= S_DONE;
                            gen_valid_q   <= 1'b0;
                            module_done_q <= 1'b1;
                        end else begin
                            index_q <= index_q + GEN_NUM_WIDTH'(1);
                            data_q  <= buffer_mem[rd_addr_d];
                        end
                    end
                end
                S_DONE: begin
                    state_q       <= S_IDLE;
                    module_done_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
                default: begin
                    state_q       <= S_IDLE;
                    gen_valid_q   <= 1'b0;
                    module_done_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gen_valid       = gen_valid_q;
    assign bus.gen_fixed_point = data_q;
    assign bus.gen_index       = index_q;
    assign bus.busy            = busy_q;
    assign bus.module_done     = module_done_q;
endmodule

// File: tb/tb_e1_gen_fixed_point.sv
// Self-checking bench for e1_gen_fixed_point: directed run sequence with random
// data, random backpressure and random write attempts, checked against a sample
// array model of what each run must emit.
module tb_e1_gen_fixed_point;
    localparam int GEN_NUM = 6;
    localparam int W       = $clog2(GEN_NUM);
    localparam int N       = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    e1_gen_fixed_point_if #(.GEN_NUM(GEN_NUM), .N(N)) bus ();

    e1_gen_fixed_point #(.GEN_NUM(GEN_NUM), .N(N), .Q(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: what the sample buffer should hold
    logic [N-1:0] model_mem [GEN_NUM];
    int compared   = 0;
    int mismatched = 0;
    bit ready_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input bit v, input bit b, input bit d);
        check({tag, "_valid"}, 64'(bus.gen_valid), 64'(v));
        check({tag, "_busy"},  64'(bus.busy),      64'(b));
        check({tag, "_done"},  64'(bus.module_done), 64'(d));
    endtask

    // Idle write; model only accepts in-range indices.
    task automatic load(input int idx, input logic [N-1:0] data);
        bus.load_en    = 1'b1;
        bus.load_index = W'(idx);
        bus.load_data  = data;
        if (idx < GEN_NUM) model_mem[idx] = data;
        @(posedge clk); #1;
        bus.load_en = 1'b0;
    endtask

    // Start request, optionally with a same-cycle write to index 0.
    task automatic start_run(input bit fwd, input logic [N-1:0] fwd_data, input bit keep_en);
        bus.module_en = 1'b1;
        if (fwd) begin
            bus.load_en    = 1'b1;
            bus.load_index = '0;
            bus.load_data  = fwd_data;
            model_mem[0]   = fwd_data;
        end
        @(posedge clk); #1;
        bus.load_en = 1'b0;
        if (!keep_en) bus.module_en = 1'b0;
    endtask

    // Consume up to 'limit' samples. mode 0: ready high, 1: random, 2: fixed pattern.
    // Random write attempts are issued throughout; the buffer must ignore them.
    task automatic stream(input int mode, input int limit, input string tag);
        int k = 0;
        int cycles = 0;
        bit r;
        while (k < limit && cycles < 400) begin
            @(negedge clk);
            check({tag, "_valid"}, 64'(bus.gen_valid), 64'd1);
            check({tag, "_index"}, 64'(bus.gen_index), 64'(k));
            check({tag, "_data"},  bus.gen_fixed_point, model_mem[k]);
            check({tag, "_done_low"}, 64'(bus.module_done), 64'd0);
            check({tag, "_busy"},  64'(bus.busy), 64'd1);
            case (mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 2) != 0);
                default: r = ready_pat[cycles % 7];
            endcase
            bus.gen_ready  = r;
            bus.load_en    = ($urandom_range(0, 1) == 1);
            bus.load_index = W'($urandom_range(0, 7));
            bus.load_data  = {$urandom, $urandom};
            @(posedge clk); #1;
            if (r) begin
                $display("xfer %s idx=%0d data=%h", tag, k, model_mem[k]);
                k++;
            end
            cycles++;
        end
        bus.load_en = 1'b0;
        check({tag, "_xfer_count"}, 64'(k), 64'(limit));
    endtask

    // DONE cycle (with an ignored load) then the IDLE cycle.
    task automatic finish_run(input string tag);
        @(negedge clk);
        check_ctrl({tag, "_donecyc"}, 1'b0, 1'b1, 1'b1);
        bus.load_en    = 1'b1;
        bus.load_index = W'(2);
        bus.load_data  = {$urandom, $urandom};
        bus.gen_ready  = ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
        bus.load_en = 1'b0;
        @(negedge clk);
        check_ctrl({tag, "_idlecyc"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.load_en    = 1'b0;
        bus.load_index = '0;
        bus.load_data  = '0;
        bus.module_en  = 1'b0;
        bus.gen_ready  = 1'b0;
        repeat (2) @(negedge clk);
        check_ctrl("reset", 1'b0, 1'b0, 1'b0);
        check("reset_index", 64'(bus.gen_index), 64'd0);
        check("reset_data", bus.gen_fixed_point, 64'd0);
        rst = 1'b0;

        // Boundary values plus random fill; indices 6 and 7 are out of range
        load(0, 64'h0000_0000_0000_8000);
        load(1, 64'hFFFF_FFFF_FFFF_8000);
        load(2, 64'h0000_0000_0000_0001);
        load(3, 64'h7FFF_FFFF_FFFF_FFFF);
        load(4, {$urandom, $urandom});
        load(5, {$urandom, $urandom});
        load(6, 64'hBAD0_BAD0_BAD0_0006);
        load(7, 64'hBAD0_BAD0_BAD0_0007);

        // Full-rate run
        start_run(1'b0, '0, 1'b0);
        stream(0, GEN_NUM, "full_rate");
        finish_run("full_rate");

        // Fixed backpressure pattern
        start_run(1'b0, '0, 1'b0);
        stream(2, GEN_NUM, "pattern_bp");
        finish_run("pattern_bp");

        // Random backpressure
        start_run(1'b0, '0, 1'b0);
        stream(1, GEN_NUM, "random_bp");
        finish_run("random_bp");

        // Same-cycle start and write to index 0, then a plain replay
        start_run(1'b1, 64'h0000_0000_0000_ABCD, 1'b0);
        stream(1, GEN_NUM, "forward");
        finish_run("forward");
        start_run(1'b0, '0, 1'b0);
        stream(0, GEN_NUM, "forward_replay");
        finish_run("forward_replay");

        // New random data, module_en held high for back-to-back runs
        for (int i = 0; i < GEN_NUM; i++) load(i, {$urandom, $urandom});
        start_run(1'b0, '0, 1'b1);
        stream(1, GEN_NUM, "held_en_a");
        finish_run("held_en_a");
        @(posedge clk); #1;
        bus.module_en = 1'b0;
        stream(0, GEN_NUM, "held_en_b");
        finish_run("held_en_b");

        // Asynchronous reset after two transfers, then replay from index 0
        start_run(1'b0, '0, 1'b0);
        stream(0, 2, "pre_reset");
        #2 rst = 1'b1;
        #1;
        check_ctrl("async_reset", 1'b0, 1'b0, 1'b0);
        check("async_reset_index", 64'(bus.gen_index), 64'd0);
        check("async_reset_data", bus.gen_fixed_point, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_ctrl("post_reset", 1'b0, 1'b0, 1'b0);
        end
        start_run(1'b0, '0, 1'b0);
        stream(1, GEN_NUM, "after_reset");
        finish_run("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
